// File: rtl/mrd_tlp_requester.sv
// rtl/mrd_tlp_requester.sv - MRd32 TLP header requester with PCIe read-tag pool
//
// Purpose:
//   Accepts one DMA read request at a time. Checks it against MRRS and the
//   4 KB boundary. For an accepted request it allocates the next read tag,
//   emits one 3DW MRd32 header on a 128-bit TX stream and reports completion.
//   Tags are returned by the completion packer.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   pcie_dcommand[15:0]     Device Control register; [14:12] = MRRS encoding
//   cfg_requester_id[15:0]  bus/dev/func placed in DW1
//   dma_read_addr/len/valid request in (len in DW, 0 = 1024); held until done
//   dma_read_done/err       one-cycle completion pulse; err marks a rejection
//   current_tag[7:0]        tag the pending or next request uses
//   tag_release_valid/tag   packer returns a tag to the pool
//   all_tags_free           no tag outstanding
//   tx_tdata/tkeep/tlast/tvalid/tready  header stream, DW0 in [31:0]

module mrd_tlp_requester #(
  parameter int p_tags = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [15:0]  pcie_dcommand,
  input  logic [15:0]  cfg_requester_id,
  input  logic [31:0]  dma_read_addr,
  input  logic [9:0]   dma_read_len,
  input  logic         dma_read_valid,
  output logic         dma_read_done,
  output logic         dma_read_err,
  output logic [7:0]   current_tag,
  input  logic         tag_release_valid,
  input  logic [7:0]   tag_release_tag,
  output logic         all_tags_free,
  output logic [127:0] tx_tdata,
  output logic [15:0]  tx_tkeep,
  output logic         tx_tlast,
  output logic         tx_tvalid,
  input  logic         tx_tready
);

  localparam int c_ptr_w = (p_tags > 1) ? $clog2(p_tags) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_WAIT_TAG,
    S_SEND,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               next_state;
  logic [31:0]          r_addr;
  logic [9:0]           r_len;
  logic [c_ptr_w-1:0]   r_ptr;
  logic [p_tags-1:0]    r_bitmap;
  logic [p_tags-1:0]    bitmap_next;
  logic                 r_all_free;
  logic                 r_tvalid;
  logic [127:0]         r_tdata;
  logic                 r_done;
  logic                 r_err;

  logic [12:0]          req_bytes;
  logic [12:0]          mrrs_bytes;
  logic [13:0]          end_offset;
  logic                 req_bad;
  logic                 tag_busy;
  logic                 send_accept;
  logic                 rel_hit;
  logic [7:0]           tag8;
  logic [3:0]           last_be;
  logic [127:0]         hdr;
  logic                 unused_dcommand;

  assign unused_dcommand = ^{pcie_dcommand[15], pcie_dcommand[11:0]};

  // Length 0 encodes 1024 DW, i.e. 4096 bytes.
  assign req_bytes = (r_len == 10'd0) ? 13'd4096 : {1'b0, r_len, 2'b00};

  // MRRS encodings above 5 are reserved; treat them as the 4 KB maximum.
  always_comb begin
    mrrs_bytes = 13'd4096;
    case (pcie_dcommand[14:12])
      3'd0:    mrrs_bytes = 13'd128;
      3'd1:    mrrs_bytes = 13'd256;
      3'd2:    mrrs_bytes = 13'd512;
      3'd3:    mrrs_bytes = 13'd1024;
      3'd4:    mrrs_bytes = 13'd2048;
      default: mrrs_bytes = 13'd4096;
    endcase
  end

  // Ending exactly on the 4 KB boundary is legal; only crossing it is not.
  assign end_offset = {2'b00, r_addr[11:0]} + {1'b0, req_bytes};
  assign req_bad    = (req_bytes > mrrs_bytes) || (end_offset > 14'd4096);

  assign tag_busy    = r_bitmap[r_ptr];
  assign send_accept = (r_state == S_SEND) && tx_tready;

  // Out-of-range tags would alias onto a low tag if only the low bits were
  // used, so they are filtered before touching the bitmap.
  assign rel_hit = tag_release_valid && ({1'b0, tag_release_tag} < 9'(p_tags));

  // Clear first, then set: a same-cycle release of another tag and the
  // allocation both land.
  always_comb begin
    bitmap_next = r_bitmap;
    if (rel_hit) begin
      bitmap_next[tag_release_tag[c_ptr_w-1:0]] = 1'b0;
    end
    if (send_accept) begin
      bitmap_next[r_ptr] = 1'b1;
    end
  end

  always_comb begin
    next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (dma_read_valid) next_state = S_CHECK;
      end
      S_CHECK: begin
        if (req_bad)       next_state = S_DONE;
        else if (tag_busy) next_state = S_WAIT_TAG;
        else               next_state = S_SEND;
      end
      S_WAIT_TAG: begin
        if (!tag_busy) next_state = S_SEND;
      end
      S_SEND: begin
        if (tx_tready) next_state = S_DONE;
      end
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Header assembly: DW0 carries only the length, all other DW0 fields are 0.
  assign tag8    = 8'(r_ptr);
  assign last_be = (r_len == 10'd1) ? 4'h0 : 4'hF;
  assign hdr     = {32'h0000_0000,
                    {r_addr[31:2], 2'b00},
                    {cfg_requester_id, tag8, last_be, 4'hF},
                    {22'd0, r_len}};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_len      <= '0;
      r_ptr      <= '0;
      r_bitmap   <= '0;
      r_all_free <= 1'b1;
      r_tvalid   <= 1'b0;
      r_tdata    <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= next_state;

      if ((r_state == S_IDLE) && dma_read_valid) begin
        r_addr <= dma_read_addr;
        r_len  <= dma_read_len;
      end

      r_bitmap   <= bitmap_next;
      r_all_free <= (bitmap_next == '0);

      if (send_accept) begin
        r_ptr <= r_ptr + 1'b1;
      end

      // Header is captured once on entry to SEND so it stays stable under
      // backpressure even if cfg_requester_id moves.
      r_tvalid <= (next_state == S_SEND);
      if (next_state == S_SEND) begin
        if (r_state != S_SEND) r_tdata <= hdr;
      end else begin
        r_tdata <= '0;
      end

      r_done <= (next_state == S_DONE);
      r_err  <= (r_state == S_CHECK) && (next_state == S_DONE);
    end
  end

  assign dma_read_done = r_done;
  assign dma_read_err  = r_err;
  assign current_tag   = 8'(r_ptr);
  assign all_tags_free = r_all_free;
  assign tx_tvalid     = r_tvalid;
  assign tx_tdata      = r_tdata;
  assign tx_tlast      = r_tvalid;
  assign tx_tkeep      = r_tvalid ? 16'h0FFF : 16'h0000;

endmodule

// File: tb/tb_mrd_tlp_requester.sv
// tb/tb_mrd_tlp_requester.sv - self-checking bench for mrd_tlp_requester

module tb_mrd_tlp_requester;

  localparam int c_tags = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [15:0]  pcie_dcommand = '0;
  logic [15:0]  cfg_requester_id = '0;
  logic [31:0]  dma_read_addr = '0;
  logic [9:0]   dma_read_len = '0;
  logic         dma_read_valid = 1'b0;
  logic         dma_read_done;
  logic         dma_read_err;
  logic [7:0]   current_tag;
  logic         tag_release_valid = 1'b0;
  logic [7:0]   tag_release_tag = '0;
  logic         all_tags_free;
  logic [127:0] tx_tdata;
  logic [15:0]  tx_tkeep;
  logic         tx_tlast;
  logic         tx_tvalid;
  logic         tx_tready = 1'b1;

  always #5 clk = ~clk;

  mrd_tlp_requester #(.p_tags(c_tags)) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .pcie_dcommand     (pcie_dcommand),
    .cfg_requester_id  (cfg_requester_id),
    .dma_read_addr     (dma_read_addr),
    .dma_read_len      (dma_read_len),
    .dma_read_valid    (dma_read_valid),
    .dma_read_done     (dma_read_done),
    .dma_read_err      (dma_read_err),
    .current_tag       (current_tag),
    .tag_release_valid (tag_release_valid),
    .tag_release_tag   (tag_release_tag),
    .all_tags_free     (all_tags_free),
    .tx_tdata          (tx_tdata),
    .tx_tkeep          (tx_tkeep),
    .tx_tlast          (tx_tlast),
    .tx_tvalid         (tx_tvalid),
    .tx_tready         (tx_tready)
  );

  int checks = 0;
  int failures = 0;

  // Reference tag pool
  bit m_busy[c_tags];
  int m_ptr;

  // Observations from the last run_req
  bit           o_done, o_err, o_saw_tv, o_unstable, o_keep_bad;
  logic [127:0] o_hdr;
  int           o_done_cyc, o_acc_cyc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    for (int i = 0; i < c_tags; i++) m_busy[i] = 1'b0;
    m_ptr = 0;
  endfunction

  function automatic void model_alloc();
    m_busy[m_ptr] = 1'b1;
    m_ptr = (m_ptr + 1) % c_tags;
  endfunction

  function automatic void model_release(input int t);
    if (t < c_tags) m_busy[t] = 1'b0;
  endfunction

  function automatic bit model_all_free();
    for (int i = 0; i < c_tags; i++) if (m_busy[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit model_reject(input logic [31:0] a, input int l, input int enc);
    int bytes, mrrs;
    bytes = ((l == 0) ? 1024 : l) * 4;
    mrrs  = (enc >= 6) ? 4096 : (128 << enc);
    return (bytes > mrrs) || ((int'(a[11:0]) + bytes) > 4096);
  endfunction

  function automatic logic [127:0] model_hdr(input logic [31:0] a, input int l,
                                             input logic [15:0] rid, input int tag);
    logic [31:0] dw0, dw1, dw2;
    dw0 = 32'(l % 1024);
    dw1 = {rid, 8'(tag), (l == 1) ? 8'h0F : 8'hFF};
    dw2 = a & 32'hFFFF_FFFC;
    return {32'h0, dw2, dw1, dw0};
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    dma_read_valid = 1'b0;
    tag_release_valid = 1'b0;
    tx_tready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    model_reset();
  endtask

  task automatic release_tag(input int t);
    tag_release_valid = 1'b1;
    tag_release_tag = 8'(t);
    tick();
    tag_release_valid = 1'b0;
    model_release(t);
  endtask

  // Drives one request from an IDLE cycle (cycle 0) and records what the
  // DUT produced; returns in the IDLE cycle following done.
  task automatic run_req(input logic [31:0] a, input logic [9:0] l,
                         input logic [2:0] enc, input bit rand_ready);
    o_done = 0; o_err = 0; o_saw_tv = 0; o_unstable = 0; o_keep_bad = 0;
    o_hdr = '0; o_done_cyc = -1; o_acc_cyc = -1;
    dma_read_addr  = a;
    dma_read_len   = l;
    pcie_dcommand  = {1'b0, enc, 12'h000};
    dma_read_valid = 1'b1;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      tick();
      if (dma_read_done) begin
        o_done = 1; o_err = dma_read_err; o_done_cyc = cyc;
        break;
      end
      if (tx_tvalid) begin
        if (!o_saw_tv) begin
          o_hdr = tx_tdata; o_saw_tv = 1;
        end else if (tx_tdata !== o_hdr) begin
          o_unstable = 1;
        end
        if (tx_tkeep !== 16'h0FFF || tx_tlast !== 1'b1) o_keep_bad = 1;
      end
      tx_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tx_tvalid && tx_tready) o_acc_cyc = cyc;
    end
    dma_read_valid = 1'b0;
    tx_tready = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({tx_tvalid, dma_read_done, dma_read_err, tx_tlast} !== 4'b0 || tx_tdata !== '0) begin
      failures++;
      $display("FAIL reset_outputs got tvalid=%b done=%b err=%b tdata=%h exp all 0",
               tx_tvalid, dma_read_done, dma_read_err, tx_tdata);
    end
    checks++;
    if (current_tag !== 8'(m_ptr)) begin
      failures++; $display("FAIL reset_tag got=%0d exp=%0d", current_tag, m_ptr);
    end
    checks++;
    if (all_tags_free !== 1'b1) begin
      failures++; $display("FAIL reset_all_free got=%b exp=1", all_tags_free);
    end
  endtask

  task automatic test_basic();
    logic [127:0] exp;
    cfg_requester_id = 16'hABCD;
    exp = model_hdr(32'h1000_0040, 16, 16'hABCD, m_ptr);
    run_req(32'h1000_0040, 10'd16, 3'd2, 1'b0);
    model_alloc();
    checks++;
    if (!o_done || o_done_cyc != 3 || o_err) begin
      failures++;
      $display("FAIL basic_done got done=%b cyc=%0d err=%b exp done at 3 err=0", o_done, o_done_cyc, o_err);
    end
    checks++;
    if (o_hdr !== exp || o_keep_bad) begin
      failures++; $display("FAIL basic_hdr got=%h keep_bad=%b exp=%h", o_hdr, o_keep_bad, exp);
    end
    checks++;
    if (current_tag !== 8'(m_ptr) || all_tags_free !== model_all_free()) begin
      failures++;
      $display("FAIL basic_tag got tag=%0d free=%b exp tag=%0d free=%b",
               current_tag, all_tags_free, m_ptr, model_all_free());
    end
  endtask

  task automatic test_lengths();
    logic [127:0] exp;
    exp = model_hdr(32'h20, 1, cfg_requester_id, m_ptr);
    run_req(32'h0000_0020, 10'd1, 3'd2, 1'b0);
    model_alloc();
    checks++;
    if (!o_done || o_err || o_hdr !== exp || o_hdr[39:32] !== 8'h0F) begin
      failures++;
      $display("FAIL len1_hdr got=%h err=%b exp=%h", o_hdr, o_err, exp);
    end
    exp = model_hdr(32'h0, 0, cfg_requester_id, m_ptr);
    run_req(32'h0000_0000, 10'd0, 3'd5, 1'b0);
    model_alloc();
    checks++;
    if (!o_done || o_err || o_hdr !== exp || o_hdr[9:0] !== 10'd0) begin
      failures++;
      $display("FAIL len1024_hdr got=%h err=%b exp=%h", o_hdr, o_err, exp);
    end
  endtask

  task automatic test_reject();
    run_req(32'h0000_0000, 10'd256, 3'd0, 1'b0);
    checks++;
    if (!o_done || o_err !== model_reject(32'h0, 256, 0) || o_done_cyc != 2 || o_saw_tv) begin
      failures++;
      $display("FAIL reject_mrrs got done=%b err=%b cyc=%0d tvalid_seen=%b exp err=1 cyc=2 no tvalid",
               o_done, o_err, o_done_cyc, o_saw_tv);
    end
    checks++;
    if (current_tag !== 8'(m_ptr)) begin
      failures++; $display("FAIL reject_ptr got=%0d exp=%0d", current_tag, m_ptr);
    end
    run_req(32'h0000_0FF0, 10'd8, 3'd5, 1'b0);
    checks++;
    if (!o_done || o_err !== model_reject(32'h0FF0, 8, 5) || o_saw_tv) begin
      failures++;
      $display("FAIL reject_4k got done=%b err=%b tvalid_seen=%b exp err=1", o_done, o_err, o_saw_tv);
    end
  endtask

  task automatic test_tag_exhaust();
    logic [127:0] exp;
    bit stalled_ok;
    apply_reset();
    for (int i = 0; i < c_tags; i++) begin
      exp = model_hdr(32'(i * 64), 4, cfg_requester_id, m_ptr);
      run_req(32'(i * 64), 10'd4, 3'd2, 1'b0);
      model_alloc();
      checks++;
      if (!o_done || o_err || o_hdr !== exp) begin
        failures++; $display("FAIL fill_tag%0d got=%h exp=%h", i, o_hdr, exp);
      end
    end
    checks++;
    if (all_tags_free !== model_all_free() || current_tag !== 8'(m_ptr)) begin
      failures++;
      $display("FAIL full_pool got free=%b tag=%0d exp free=0 tag=%0d", all_tags_free, current_tag, m_ptr);
    end
    exp = model_hdr(32'h0000_0800, 4, cfg_requester_id, 0);
    dma_read_addr = 32'h0000_0800;
    dma_read_len = 10'd4;
    dma_read_valid = 1'b1;
    stalled_ok = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (dma_read_done || tx_tvalid) stalled_ok = 0;
    end
    checks++;
    if (!stalled_ok) begin
      failures++; $display("FAIL wait_tag_stall got done/tvalid during stall exp none");
    end
    release_tag(0);
    checks++;
    if (tx_tvalid !== 1'b0) begin
      failures++; $display("FAIL wait_tag_early got tvalid=%b exp=0", tx_tvalid);
    end
    tick();
    checks++;
    if (tx_tvalid !== 1'b1 || tx_tdata !== exp) begin
      failures++; $display("FAIL wait_tag_send got tvalid=%b tdata=%h exp 1 %h", tx_tvalid, tx_tdata, exp);
    end
    tick();
    model_alloc();
    checks++;
    if (dma_read_done !== 1'b1 || dma_read_err !== 1'b0) begin
      failures++; $display("FAIL wait_tag_done got done=%b err=%b exp 1 0", dma_read_done, dma_read_err);
    end
    dma_read_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure_reset();
    logic [127:0] exp;
    bit stable_ok;
    apply_reset();
    exp = model_hdr(32'h0000_0100, 32, cfg_requester_id, m_ptr);
    dma_read_addr = 32'h0000_0100;
    dma_read_len = 10'd32;
    pcie_dcommand = {1'b0, 3'd3, 12'h000};
    tx_tready = 1'b0;
    dma_read_valid = 1'b1;
    tick();
    tick();
    stable_ok = (tx_tvalid === 1'b1) && (tx_tdata === exp);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (tx_tvalid !== 1'b1 || tx_tdata !== exp || dma_read_done !== 1'b0) stable_ok = 0;
    end
    checks++;
    if (!stable_ok) begin
      failures++; $display("FAIL bp_stable got tdata=%h exp=%h held", tx_tdata, exp);
    end
    tx_tready = 1'b1;
    tick();
    model_alloc();
    checks++;
    if (dma_read_done !== 1'b1) begin
      failures++; $display("FAIL bp_done got done=%b exp=1", dma_read_done);
    end
    dma_read_valid = 1'b0;
    tick();
    tx_tready = 1'b0;
    dma_read_valid = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (tx_tvalid !== 1'b1 || current_tag !== 8'(m_ptr) || all_tags_free !== 1'b0) begin
      failures++;
      $display("FAIL pre_reset got tvalid=%b tag=%0d free=%b exp 1 %0d 0", tx_tvalid, current_tag, m_ptr, all_tags_free);
    end
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (tx_tvalid !== 1'b0 || all_tags_free !== 1'b1 || current_tag !== 8'(m_ptr) || dma_read_done !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got tvalid=%b free=%b tag=%0d done=%b exp 0 1 0 0",
               tx_tvalid, all_tags_free, current_tag, dma_read_done);
    end
    dma_read_valid = 1'b0;
    tx_tready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_release_alloc();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      run_req(32'(i * 16), 10'd2, 3'd2, 1'b0);
      model_alloc();
    end
    dma_read_addr = 32'h0000_0400;
    dma_read_len = 10'd2;
    dma_read_valid = 1'b1;
    tick();
    tick();
    checks++;
    if (tx_tvalid !== 1'b1 || tx_tdata[47:40] !== 8'(m_ptr)) begin
      failures++; $display("FAIL ra_send got tvalid=%b tag=%0d exp 1 %0d", tx_tvalid, tx_tdata[47:40], m_ptr);
    end
    tag_release_valid = 1'b1;
    tag_release_tag = 8'd3;
    tick();
    tag_release_valid = 1'b0;
    model_alloc();
    model_release(3);
    dma_read_valid = 1'b0;
    tick();
    release_tag(3);
    release_tag(9);
    release_tag(0);
    release_tag(2);
    release_tag(4);
    checks++;
    if (all_tags_free !== model_all_free()) begin
      failures++; $display("FAIL ra_partial got free=%b exp=%b", all_tags_free, model_all_free());
    end
    release_tag(1);
    checks++;
    if (all_tags_free !== model_all_free() || current_tag !== 8'(m_ptr)) begin
      failures++;
      $display("FAIL ra_all got free=%b tag=%0d exp free=%b tag=%0d",
               all_tags_free, current_tag, model_all_free(), m_ptr);
    end
  endtask

  task automatic test_random();
    logic [127:0] exp;
    logic [31:0]  a;
    int           l, enc;
    bit           exp_err;
    apply_reset();
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 1) == 1) release_tag($urandom_range(0, 11));
      if (m_busy[m_ptr]) release_tag(m_ptr);
      cfg_requester_id = 16'($urandom);
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[11:0] = 12'($urandom_range(0, 255));
      enc = $urandom_range(0, 7);
      l = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(1, 32);
      exp_err = model_reject(a, l, enc);
      exp = model_hdr(a, l, cfg_requester_id, m_ptr);
      run_req(a, 10'(l), 3'(enc), 1'b1);
      checks++;
      if (!o_done || o_err !== exp_err) begin
        failures++;
        $display("FAIL rnd%0d_done got done=%b err=%b exp err=%b a=%h l=%0d enc=%0d",
                 n, o_done, o_err, exp_err, a, l, enc);
      end
      if (!exp_err) begin
        model_alloc();
        checks++;
        if (o_hdr !== exp || o_unstable || o_keep_bad || o_done_cyc != o_acc_cyc + 1) begin
          failures++;
          $display("FAIL rnd%0d_hdr got=%h unstable=%b keep_bad=%b done_cyc=%0d acc_cyc=%0d exp=%h",
                   n, o_hdr, o_unstable, o_keep_bad, o_done_cyc, o_acc_cyc, exp);
        end
      end else begin
        checks++;
        if (o_saw_tv || o_done_cyc != 2) begin
          failures++;
          $display("FAIL rnd%0d_rej got tvalid_seen=%b cyc=%0d exp 0 2", n, o_saw_tv, o_done_cyc);
        end
      end
      checks++;
      if (current_tag !== 8'(m_ptr) || all_tags_free !== model_all_free()) begin
        failures++;
        $display("FAIL rnd%0d_pool got tag=%0d free=%b exp tag=%0d free=%b",
                 n, current_tag, all_tags_free, m_ptr, model_all_free());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_lengths();
    test_reject();
    test_tag_exhaust();
    test_backpressure_reset();
    test_release_alloc();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
